wisc_mc_ctrl: RTL
=================

Name: wisc_mc_ctrl

Overview:
- Multi-cycle control FSM for the 16-bit WISC core.
- Latches the fetched instruction and sequences fetch/decode/execute/memory/writeback. Handshakes with instruction and data memories.
- Drives the sign-extender configuration (SignExt, NineBits) from the latched opcode. Keeps a retired-instruction counter and a memory-wait watchdog.

Parameters:
- WAIT_LIMIT, 15: max cycles a memory request may wait for ready before fault.
- CNT_W, 16: width of retired-instruction counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- instr  in  16  instruction word from imem, valid when imem_rdy=1.
- imem_rdy  in  1  imem data valid.
- dmem_rdy  in  1  dmem access complete.
- br_taken  in  1  branch condition result from flag logic (valid in EXEC).
- imem_req  out  1  instruction fetch request.
- dmem_req  out  1  data memory request.
- dmem_wr  out  1  data write (SW) qualifier for dmem_req.
- ir  out  16  latched instruction register.
- sext_en  out  1  SignExt to sign extender.
- sext_nine  out  1  NineBits to sign extender.
- pc_en  out  1  PC update strobe.
- pc_sel  out  1  0 = PC+2, 1 = branch target.
- rf_we  out  1  register-file write enable.
- halted  out  1  core halted (HLT or fault).
- fault  out  1  memory-wait timeout occurred.
- retired  out  CNT_W  count of completed instructions.

Behaviour:
- Reset (async, rst_n=0):
  - state=FETCH, ir=16'h0000, wait_cnt=0, retired=0, fault=0.
  - Every output 0. imem_req is gated by rst_n.
- States: FETCH, DECODE, EXEC, MEM, WB, HALT. Outputs are Moore-decoded from state and ir.
- FETCH:
  - imem_req=1 until imem_rdy.
  - On imem_rdy: ir<=instr, wait_cnt<=0, go DECODE.
- DECODE:
  - opc=ir[15:12]. opc=4'hF (HLT): go HALT, retired+1.
  - Otherwise go EXEC.
- EXEC:
  - opc 0x0-0x7, 0xA, 0xB, 0xE: go WB.
  - opc 0x8 (LW), 0x9 (SW): go MEM.
  - opc 0xC (B), 0xD (BR): pc_en=1, pc_sel=br_taken, retired+1, go FETCH.
- MEM:
  - dmem_req=1 until dmem_rdy; dmem_wr=1 iff opc=0x9.
  - On dmem_rdy: SW → pc_en=1, pc_sel=0, retired+1, go FETCH. LW → go WB.
- WB: rf_we=1, pc_en=1, pc_sel=0, retired+1, go FETCH. One cycle only.
- HALT: halted=1. Absorbing until rst_n low. No requests issued, ir frozen.
- Sign-extender configuration: combinational from ir, valid from DECODE through end of the instruction.
  - B (0xC): sext_en=1, sext_nine=1.
  - LW/SW (0x8/0x9): sext_en=1, sext_nine=0.
  - All other opcodes: sext_en=0, sext_nine=0 (zero-extended 4-bit immediate).
  - In FETCH and HALT: both 0.
- Watchdog:
  - wait_cnt increments each cycle in FETCH without imem_rdy, or in MEM without dmem_rdy. It is cleared on state exit.
  - When wait_cnt reaches WAIT_LIMIT with ready still low: fault<=1, go HALT. No ir load, no retire.
  - Ready arriving in the same cycle wait_cnt==WAIT_LIMIT wins (no fault).
- retired: wraps modulo 2^CNT_W. Increments exactly once per instruction, in the cycle pc_en=1 (or on HLT entry).
- Latency, zero-wait memory:
  - ALU/LLB/LHB/PCS: 4 cycles.
  - LW: 5 cycles.
  - SW: 4 cycles.
  - B/BR: 3 cycles.
- Ready signals outside their request state are ignored.
- Reset mid-instruction: immediate return to reset values. The in-flight instruction is not retired.

Test Plan:
- Reset then instr=16'h0123 (ADD), imem_rdy=1 every cycle → states FETCH, DECODE, EXEC, WB; rf_we=1 in cycle 4; retired=1; sext_en=0.
- instr=16'h8214 (LW), dmem_rdy delayed 3 cycles → dmem_req high 4 cycles, dmem_wr=0; sext_en=1, sext_nine=0; rf_we in WB; retired=1.
- instr=16'hC1FF (B), br_taken=1 → sext_en=1, sext_nine=1; pc_en=1 with pc_sel=1 in EXEC; no rf_we; next state FETCH.
- instr=16'h9214 (SW), dmem_rdy never asserted, WAIT_LIMIT=15 → fault=1 and halted=1 after 15 wait cycles; retired unchanged; dmem_req drops.
- instr=16'hF000 → halted=1 after DECODE, stays with imem_rdy toggling; rst_n pulse low → halted=0, retired=0, state=FETCH.
- rst_n asserted low during MEM of an SW → all outputs 0 immediately; after release, fetch restarts and retired=0.

Source files
------------

// File: rtl/wisc_mc_ctrl_if.sv
// Memory handshake bundle between the WISC multi-cycle controller and
// its instruction/data memories.
interface wisc_mc_ctrl_if;
    logic [15:0] instr;
    logic        imem_req;
    logic        imem_rdy;
    logic        dmem_req;
    logic        dmem_rdy;
    logic        dmem_wr;

    modport master (
        output imem_req, dmem_req, dmem_wr,
        input  instr, imem_rdy, dmem_rdy
    );

    modport slave (
        input  imem_req, dmem_req, dmem_wr,
        output instr, imem_rdy, dmem_rdy
    );
endinterface

// File: rtl/wisc_mc_ctrl.sv
// Multi-cycle control FSM for the 16-bit WISC core: latches the fetched
// instruction, sequences FETCH/DECODE/EXEC/MEM/WB, drives the sign-extender
// configuration, counts retired instructions and guards memory waits.
module wisc_mc_ctrl #(
    parameter int unsigned WAIT_LIMIT = 15,
    parameter int unsigned CNT_W      = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    wisc_mc_ctrl_if.master       bus,
    input  logic                 br_taken,
    output logic [15:0]          ir,
    output logic                 sext_en,
    output logic                 sext_nine,
    output logic                 pc_en,
    output logic                 pc_sel,
    output logic                 rf_we,
    output logic                 halted,
    output logic                 fault,
    output logic [CNT_W-1:0]     retired
);

    localparam int unsigned   WW       = (WAIT_LIMIT < 1) ? 1 : $clog2(WAIT_LIMIT + 1);
    localparam logic [WW-1:0] WAIT_MAX = WW'(WAIT_LIMIT);

    typedef enum logic [2:0] {
        FETCH,
        DECODE,
        EXEC,
        MEM,
        WB,
        HALT
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [WW-1:0] wait_cnt;
    logic [3:0]    opc;
    logic          ir_ld;
    logic          retire;
    logic          waiting;
    logic          wd_trip;
    logic          imem_req_st;
    logic          dmem_req_c;
    logic          dmem_wr_c;

    assign opc = ir[15:12];

    // imem_req is gated by rst_n so nothing is requested while reset is held
    assign bus.imem_req = imem_req_st & rst_n;
    assign bus.dmem_req = dmem_req_c;
    assign bus.dmem_wr  = dmem_wr_c;
    assign halted       = (state == HALT);

    // State, instruction register, watchdog, fault flag and retire counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= FETCH;
            ir       <= '0;
            wait_cnt <= '0;
            fault    <= 1'b0;
            retired  <= '0;
        end else begin
            state <= state_nxt;
            if (ir_ld) begin
                ir <= bus.instr;
            end
            if (state_nxt != state) begin
                wait_cnt <= '0;
            end else if (waiting) begin
                wait_cnt <= wait_cnt + 1'b1;
            end
            if (wd_trip) begin
                fault <= 1'b1;
            end
            if (retire) begin
                retired <= retired + 1'b1;
            end
        end
    end

    // Next-state and control strobes; a ready arriving on the limit cycle wins
    always_comb begin
        state_nxt   = state;
        ir_ld       = 1'b0;
        retire      = 1'b0;
        waiting     = 1'b0;
        wd_trip     = 1'b0;
        imem_req_st = 1'b0;
        dmem_req_c  = 1'b0;
        dmem_wr_c   = 1'b0;
        pc_en       = 1'b0;
        pc_sel      = 1'b0;
        rf_we       = 1'b0;
        case (state)
            FETCH: begin
                imem_req_st = 1'b1;
                if (bus.imem_rdy) begin
                    ir_ld     = 1'b1;
                    state_nxt = DECODE;
                end else if (wait_cnt == WAIT_MAX) begin
                    wd_trip   = 1'b1;
                    state_nxt = HALT;
                end else begin
                    waiting = 1'b1;
                end
            end
            DECODE: begin
                if (opc == 4'hF) begin
                    retire    = 1'b1;
                    state_nxt = HALT;
                end else begin
                    state_nxt = EXEC;
                end
            end
            EXEC: begin
                case (opc)
                    4'h8, 4'h9: state_nxt = MEM;
                    4'hC, 4'hD: begin
                        pc_en     = 1'b1;
                        pc_sel    = br_taken;
                        retire    = 1'b1;
                        state_nxt = FETCH;
                    end
                    default: state_nxt = WB;
                endcase
            end
            MEM: begin
                dmem_req_c = 1'b1;
                dmem_wr_c  = (opc == 4'h9);
                if (bus.dmem_rdy) begin
                    if (opc == 4'h9) begin
                        pc_en     = 1'b1;
                        retire    = 1'b1;
                        state_nxt = FETCH;
                    end else begin
                        state_nxt = WB;
                    end
                end else if (wait_cnt == WAIT_MAX) begin
                    wd_trip   = 1'b1;
                    state_nxt = HALT;
                end else begin
                    waiting = 1'b1;
                end
            end
            WB: begin
                rf_we     = 1'b1;
                pc_en     = 1'b1;
                retire    = 1'b1;
                state_nxt = FETCH;
            end
            HALT: begin
                state_nxt = HALT;
            end
            default: state_nxt = FETCH;
        endcase
    end

    // Sign-extender configuration from the latched opcode, live DECODE..WB
    always_comb begin
        sext_en   = 1'b0;
        sext_nine = 1'b0;
        if (state inside {DECODE, EXEC, MEM, WB}) begin
            case (opc)
                4'hC: begin
                    sext_en   = 1'b1;
                    sext_nine = 1'b1;
                end
                4'h8, 4'h9: sext_en = 1'b1;
                default: ;
            endcase
        end
    end

endmodule
